multi_cycle_ctrl: RTL

- Multi-cycle controller FSM that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the ALU opcode, all datapath mux selects and write enables, and consumes the ALU compare result.
- Sits between the instruction register and the datapath (PC, IR, GRF, DM, ALU). It replaces the single-cycle combinational controller in the multi-cycle CPU.

---
 rtl/ctrl_pkg.sv | 69 ++++++
 rtl/instr_class_decode.sv | 38 +++
 rtl/multi_cycle_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multi-cycle controller and its datapath.
package ctrl_pkg;

  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned INSTR_W  = 32;

  // Primary opcodes (instr[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;

  // R-type function codes (instr[5:0])
  localparam logic [OP_W-1:0] FUNCT_ADDU = 6'b100001;
  localparam logic [OP_W-1:0] FUNCT_SUBU = 6'b100011;
  localparam logic [OP_W-1:0] FUNCT_FLIP = 6'b111111;

  // ALU operation codes, shared with the ALU
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_EQ   = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_FLIP = 3'b100;

  // Next-PC select
  localparam logic [SEL_W-1:0] NPC_PC4    = 2'b00;
  localparam logic [SEL_W-1:0] NPC_BRANCH = 2'b01;

  // GRF destination select
  localparam logic [SEL_W-1:0] REG_DST_RT = 2'b00;
  localparam logic [SEL_W-1:0] REG_DST_RD = 2'b01;

  // GRF write-data select
  localparam logic [SEL_W-1:0] WD_ALU = 2'b00;
  localparam logic [SEL_W-1:0] WD_MEM = 2'b01;

  // ALU B-operand select
  localparam logic [SEL_W-1:0] SRC_B_RT   = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_ZEXT = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_SEXT = 2'b10;
  localparam logic [SEL_W-1:0] SRC_B_LUI  = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  // One-hot instruction class
  typedef struct packed {
    logic r_addu;
    logic r_subu;
    logic r_flip;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic unknown;
  } instr_class_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational instruction classifier: one-hot class from opcode/funct.
module instr_class_decode
  import ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output instr_class_t       cls
);

  logic [OP_W-1:0] op;
  logic [OP_W-1:0] funct;
  logic            unused_bits;

  assign op          = instr[31:26];
  assign funct       = instr[5:0];
  assign unused_bits = ^instr[25:6];

  // Decode opcode and funct; anything unmatched is unknown
  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FUNCT_ADDU: cls.r_addu  = 1'b1;
          FUNCT_SUBU: cls.r_subu  = 1'b1;
          FUNCT_FLIP: cls.r_flip  = 1'b1;
          default:    cls.unknown = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LUI:  cls.lui     = 1'b1;
      OP_LW:   cls.lw      = 1'b1;
      OP_SW:   cls.sw      = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      default: cls.unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// datapath controls decoded from the current state and instruction class.
module multi_cycle_ctrl
  import ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                alu_eq,
  output logic                pc_we,
  output logic [SEL_W-1:0]    npc_sel,
  output logic                ir_we,
  output logic                reg_we,
  output logic [SEL_W-1:0]    reg_dst,
  output logic [SEL_W-1:0]    wd_sel,
  output logic [SEL_W-1:0]    alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_we,
  output logic [STATE_W-1:0]  state_o,
  output logic                instr_done
);

  state_t       state;
  state_t       state_nxt;
  instr_class_t cls;
  logic         is_rtype;

  instr_class_decode u_decode (
    .instr (instr),
    .cls   (cls)
  );

  assign is_rtype = cls.r_addu | cls.r_subu | cls.r_flip;
  assign state_o  = STATE_W'(state);

  // State register; reset returns to FETCH asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and datapath controls; reset masks every control to idle
  always_comb begin
    state_nxt  = ST_FETCH;
    pc_we      = 1'b0;
    npc_sel    = NPC_PC4;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = REG_DST_RT;
    wd_sel     = WD_ALU;
    alu_src_b  = SRC_B_RT;
    alu_op     = ALU_ADD;
    mem_we     = 1'b0;
    instr_done = 1'b0;
    case (state)
      ST_FETCH: begin
        state_nxt = ST_DECODE;
        if (!reset) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      ST_DECODE: begin
        if (cls.unknown) begin
          state_nxt = ST_FETCH;
          if (!reset) begin
            instr_done = 1'b1;
          end
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls.beq) begin
          state_nxt = ST_FETCH;
        end else if (cls.lw || cls.sw) begin
          state_nxt = ST_MEM;
        end else if (is_rtype || cls.ori || cls.lui) begin
          state_nxt = ST_WB;
        end else begin
          state_nxt = ST_FETCH;
        end
        if (!reset) begin
          if (cls.r_subu) begin
            alu_op = ALU_SUB;
          end else if (cls.r_flip) begin
            alu_op = ALU_FLIP;
          end else if (cls.ori) begin
            alu_op    = ALU_OR;
            alu_src_b = SRC_B_ZEXT;
          end else if (cls.lui) begin
            alu_src_b = SRC_B_LUI;
          end else if (cls.lw || cls.sw) begin
            alu_src_b = SRC_B_SEXT;
          end else if (cls.beq) begin
            alu_op     = ALU_EQ;
            npc_sel    = NPC_BRANCH;
            pc_we      = alu_eq;
            instr_done = 1'b1;
          end
        end
      end
      ST_MEM: begin
        state_nxt = cls.lw ? ST_WB : ST_FETCH;
        if (!reset && cls.sw) begin
          mem_we     = 1'b1;
          instr_done = 1'b1;
        end
      end
      ST_WB: begin
        state_nxt = ST_FETCH;
        if (!reset) begin
          reg_we     = 1'b1;
          instr_done = 1'b1;
          reg_dst    = is_rtype ? REG_DST_RD : REG_DST_RT;
          wd_sel     = cls.lw ? WD_MEM : WD_ALU;
        end
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

endmodule
